canon_code_gen: RTL and testbench
=================================

CANON_CODE_GEN -- requirements
Module: canon_code_gen

Interface
REQ-001 SHALL have parameter LIT_NSYM, default 29, number of literal/length code-length entries.
REQ-002 SHALL have parameter DIST_NSYM, default 16, number of distance code-length entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fin  input  1  level from the code-length stage; rising edge starts a build.
REQ-006 SHALL have port litTree  input  116  29 x 4-bit code lengths; symbol k at bits [4k+3:4k].
REQ-007 SHALL have port distTree  input  64  16 x 4-bit code lengths; same packing.
REQ-008 SHALL have port rd_sel  input  1  table select (0 lit, 1 dist).
REQ-009 SHALL have port rd_sym  input  5  symbol index to look up.
REQ-010 SHALL have port rd_code  output  8  canonical code, right-aligned.
REQ-011 SHALL have port rd_len  output  4  code length of the looked-up symbol.
REQ-012 SHALL have port busy  output  1  build in progress.
REQ-013 SHALL have port done  output  1  tables valid.
REQ-014 SHALL have port err  output  1  oversubscribed length set detected.

Function
REQ-015 SHALL detect a start as fin=1 while fin was 0 on the previous cycle, acting only in IDLE or DONE.
REQ-016 SHALL ignore start while busy, and SHALL ignore fin held high in DONE.
REQ-017 SHALL sequence states IDLE -> L_COUNT -> L_NEXT -> L_ASSIGN -> D_COUNT -> D_NEXT -> D_ASSIGN -> DONE; DONE -> L_COUNT on a new start.
REQ-018 COUNT SHALL visit one symbol per cycle, incrementing bl_count[len] only for len 1..8.
REQ-019 NEXT SHALL compute one length per cycle for len=1..8: code=(code+bl_count[len-1])<<1, with bl_count[0] treated as 0; next_code[len]=code; the code register is 9 bits.
REQ-020 ASSIGN SHALL visit one symbol per cycle; for len!=0 it stores code=next_code[len] and then increments next_code[len]; for len=0 it stores code 0.
REQ-021 Lengths 9..15 SHALL be treated as 0 and SHALL set err.
REQ-022 err SHALL set when, for any len in NEXT, next_code[len]+bl_count[len] > 2^len; err is sticky until the next start or reset.
REQ-023 busy SHALL be high for exactly 106 cycles (29+8+29+16+8+16) after the start-sampling edge, with done rising on the same edge busy falls.
REQ-024 Lengths SHALL be sampled from litTree/distTree in the respective COUNT state; the inputs must be stable from fin rising onward.
REQ-025 Reads SHALL be registered with 1-cycle latency; when done=0, or when rd_sym >= the selected NSYM, rd_code=0 and rd_len=0.
REQ-026 done and the tables SHALL persist until reset or a new start, and a new start SHALL clear done and err on its first edge.

Reset
REQ-027 rst SHALL asynchronously force IDLE, busy=0, done=0, err=0, rd_code=0, rd_len=0, and clear bl_count, next_code and both tables.
REQ-028 rst asserted mid-build SHALL abort the build, and the fin edge detector SHALL reset to 0 so that fin already high re-triggers a build after release.

Configuration
REQ-029 With CANON_BITREV_EN defined, rd_code SHALL return the code bit-reversed within rd_len bits (LSB-first bitstream use), with upper bits 0; without it, rd_code SHALL be MSB-first canonical.

Structure
REQ-030 Package canon_pkg SHALL hold LIT_NSYM, DIST_NSYM, MAX_LEN=8, LEN_W=4, CODE_W=8 and the state enum.
REQ-031 One sub-module, canon_tab (parameter NSYM), SHALL hold one table's lengths/codes plus its count/next/assign engine; it is instantiated twice and sequenced by the top FSM through go/ready.

Verification
REQ-032 All 29 lit lengths=5, all 16 dist lengths=4, fin rising -> done after 106 cycles; lit sym k code=k, len 5; dist sym k code=k, len 4; err=0.
REQ-033 Lit lengths sym0=1, sym1=2, sym2=3, sym3=3, others 0 -> codes 0, 10b, 110b, 111b; sym4 reads code 0, len 0.
REQ-034 Dist sym0..2 all length 1 -> err=1, and done still asserts at cycle 106.
REQ-035 With CANON_BITREV_EN and REQ-033 stimulus -> sym1 code 01b, sym2 code 011b, sym3 code 111b.
REQ-036 rst pulsed at build cycle 50 with fin held high -> busy=0, done=0, reads return 0; after release, build reruns and done rises 106 cycles later.
REQ-037 fin held high in DONE with rd_sel=0, rd_sym=29 -> no restart, rd_code=0, rd_len=0.

Source files
------------

// File: rtl/canon_pkg.sv
// Shared constants, state encodings and helpers for the canonical code generator.
package canon_pkg;

    localparam int unsigned LIT_NSYM  = 29;
    localparam int unsigned DIST_NSYM = 16;
    localparam int unsigned MAX_LEN   = 8;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned CODE_W    = 8;
    localparam int unsigned SYM_W     = 5;

    // Top-level build sequence
    typedef enum logic [2:0] {
        StIdle,
        StLCount,
        StLNext,
        StLAssign,
        StDCount,
        StDNext,
        StDAssign,
        StDone
    } state_e;

    // Work item a table engine is asked to perform this cycle
    typedef enum logic [1:0] {
        PhIdle,
        PhCount,
        PhNext,
        PhAssign
    } tab_phase_e;

    // Reverse the low 'len' bits of 'code'; bits at or above 'len' come out 0
    function automatic logic [CODE_W-1:0] bitrev(input logic [CODE_W-1:0] code,
                                                 input logic [LEN_W-1:0]  len);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            if (i < int'(len)) r[i] = code[int'(len) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/canon_tab.sv
// One code table: stores per-symbol lengths and canonical codes, and runs the
// count / next-code / assign steps one item per cycle while 'go' is high.
module canon_tab
    import canon_pkg::*;
#(
    parameter int unsigned NSYM = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  go,
    input  tab_phase_e            phase,
    input  logic [LEN_W*NSYM-1:0] tree,
    output logic                  ready,
    output logic                  err_hit,
    input  logic [SYM_W-1:0]      rd_idx,
    output logic [CODE_W-1:0]     rd_code,
    output logic [LEN_W-1:0]      rd_len
);

    localparam int unsigned CNT_W = $clog2(NSYM + 1);
    localparam int unsigned NC_W  = CODE_W + 1;

    logic [SYM_W-1:0]          idx_q;
    logic [NC_W-1:0]           code_q;
    logic [CNT_W*MAX_LEN-1:0]  bl_count_q;   // entry l-1 holds bl_count[l]
    logic [NC_W*MAX_LEN-1:0]   next_code_q;  // entry l-1 holds next_code[l]
    logic [LEN_W*NSYM-1:0]     lens_q;
    logic [CODE_W*NSYM-1:0]    codes_q;

    logic                      in_range;
    logic [LEN_W-1:0]          raw_len;
    logic                      cur_valid;
    logic [CNT_W-1:0]          cur_cnt;
    logic [NC_W-1:0]           cur_next;
    logic [LEN_W-1:0]          step_len;
    logic [CNT_W-1:0]          prev_cnt;
    logic [CNT_W-1:0]          step_cnt;
    logic [NC_W-1:0]           code_n;
    logic [NC_W:0]             span;
    logic [NC_W:0]             limit;

    // Per-cycle datapath: current symbol length, next-code step and phase end
    always_comb begin
        in_range = (idx_q < SYM_W'(NSYM));
        raw_len  = '0;
        if (in_range) begin
            if (phase == PhCount) raw_len = tree[int'(idx_q)*LEN_W +: LEN_W];
            else                  raw_len = lens_q[int'(idx_q)*LEN_W +: LEN_W];
        end
        // Lengths above MAX_LEN behave as unused symbols
        cur_valid = (raw_len != '0) && (raw_len <= LEN_W'(MAX_LEN));
        cur_cnt   = '0;
        cur_next  = '0;
        if (cur_valid) begin
            cur_cnt  = bl_count_q[(int'(raw_len) - 1)*CNT_W +: CNT_W];
            cur_next = next_code_q[(int'(raw_len) - 1)*NC_W +: NC_W];
        end

        // In the next-code phase idx_q walks len-1 = 0..MAX_LEN-1
        step_len = idx_q[LEN_W-1:0] + LEN_W'(1);
        prev_cnt = '0;
        step_cnt = '0;
        if (idx_q < SYM_W'(MAX_LEN)) begin
            step_cnt = bl_count_q[int'(idx_q)*CNT_W +: CNT_W];
            if (idx_q != '0) prev_cnt = bl_count_q[(int'(idx_q) - 1)*CNT_W +: CNT_W];
        end
        code_n = (code_q + NC_W'(prev_cnt)) << 1;
        span   = {1'b0, code_n} + (NC_W+1)'(step_cnt);
        limit  = (NC_W+1)'(1) << step_len;

        ready   = 1'b0;
        err_hit = 1'b0;
        if (go) begin
            unique case (phase)
                PhCount: begin
                    ready   = (idx_q == SYM_W'(NSYM - 1));
                    err_hit = (raw_len > LEN_W'(MAX_LEN));
                end
                PhNext: begin
                    ready   = (idx_q == SYM_W'(MAX_LEN - 1));
                    err_hit = (span > limit);
                end
                PhAssign: ready = (idx_q == SYM_W'(NSYM - 1));
                default: ;
            endcase
        end
    end

    // Engine state and table storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            code_q      <= '0;
            bl_count_q  <= '0;
            next_code_q <= '0;
            lens_q      <= '0;
            codes_q     <= '0;
        end else if (start) begin
            idx_q       <= '0;
            code_q      <= '0;
            bl_count_q  <= '0;
            next_code_q <= '0;
        end else if (go) begin
            idx_q <= ready ? '0 : idx_q + SYM_W'(1);
            unique case (phase)
                PhCount: begin
                    if (in_range) begin
                        lens_q[int'(idx_q)*LEN_W +: LEN_W] <= cur_valid ? raw_len : '0;
                    end
                    if (cur_valid) begin
                        bl_count_q[(int'(raw_len) - 1)*CNT_W +: CNT_W] <= cur_cnt + CNT_W'(1);
                    end
                end
                PhNext: begin
                    code_q <= code_n;
                    next_code_q[int'(idx_q)*NC_W +: NC_W] <= code_n;
                end
                PhAssign: begin
                    if (in_range) begin
                        codes_q[int'(idx_q)*CODE_W +: CODE_W] <=
                            cur_valid ? cur_next[CODE_W-1:0] : '0;
                    end
                    if (cur_valid) begin
                        next_code_q[(int'(raw_len) - 1)*NC_W +: NC_W] <= cur_next + NC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Unregistered lookup; the top registers the result
    always_comb begin
        rd_code = '0;
        rd_len  = '0;
        if (rd_idx < SYM_W'(NSYM)) begin
            rd_code = codes_q[int'(rd_idx)*CODE_W +: CODE_W];
            rd_len  = lens_q[int'(rd_idx)*LEN_W +: LEN_W];
        end
    end

endmodule

// File: rtl/canon_code_gen.sv
// Canonical Huffman code generator for a literal/length and a distance table.
// A rising edge on 'fin' builds both tables in a fixed 106-cycle sequence;
// afterwards codes are read through a registered lookup port.
// Define CANON_BITREV_EN to return codes bit-reversed within their length
// (LSB-first bitstream order); by default codes are MSB-first canonical.
module canon_code_gen #(
    parameter int unsigned LIT_NSYM  = canon_pkg::LIT_NSYM,
    parameter int unsigned DIST_NSYM = canon_pkg::DIST_NSYM
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  fin,
    input  logic [canon_pkg::LEN_W*LIT_NSYM-1:0]  litTree,
    input  logic [canon_pkg::LEN_W*DIST_NSYM-1:0] distTree,
    input  logic                                  rd_sel,
    input  logic [canon_pkg::SYM_W-1:0]           rd_sym,
    output logic [canon_pkg::CODE_W-1:0]          rd_code,
    output logic [canon_pkg::LEN_W-1:0]           rd_len,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);

    import canon_pkg::*;

    state_e            state;
    logic              fin_q;
    logic              start;
    logic              lit_go, dist_go;
    tab_phase_e        lit_phase, dist_phase;
    logic              lit_ready, dist_ready;
    logic              lit_err, dist_err;
    logic [CODE_W-1:0] lit_code, dist_code, sel_code;
    logic [LEN_W-1:0]  lit_len, dist_len, sel_len;

    // Only a fresh rising edge of fin, and only when not mid-build
    assign start = fin & ~fin_q & ((state == StIdle) || (state == StDone));

    // Map the top state onto the work each table engine does this cycle
    always_comb begin
        lit_go     = 1'b0;
        dist_go    = 1'b0;
        lit_phase  = PhIdle;
        dist_phase = PhIdle;
        unique case (state)
            StLCount:  begin lit_go  = 1'b1; lit_phase  = PhCount;  end
            StLNext:   begin lit_go  = 1'b1; lit_phase  = PhNext;   end
            StLAssign: begin lit_go  = 1'b1; lit_phase  = PhAssign; end
            StDCount:  begin dist_go = 1'b1; dist_phase = PhCount;  end
            StDNext:   begin dist_go = 1'b1; dist_phase = PhNext;   end
            StDAssign: begin dist_go = 1'b1; dist_phase = PhAssign; end
            default: ;
        endcase
    end

    canon_tab #(
        .NSYM (LIT_NSYM)
    ) u_lit (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .go      (lit_go),
        .phase   (lit_phase),
        .tree    (litTree),
        .ready   (lit_ready),
        .err_hit (lit_err),
        .rd_idx  (rd_sym),
        .rd_code (lit_code),
        .rd_len  (lit_len)
    );

    canon_tab #(
        .NSYM (DIST_NSYM)
    ) u_dist (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .go      (dist_go),
        .phase   (dist_phase),
        .tree    (distTree),
        .ready   (dist_ready),
        .err_hit (dist_err),
        .rd_idx  (rd_sym),
        .rd_code (dist_code),
        .rd_len  (dist_len)
    );

    // Select the addressed table and apply output bit order
    always_comb begin
        sel_len = rd_sel ? dist_len : lit_len;
`ifdef CANON_BITREV_EN
        sel_code = bitrev(rd_sel ? dist_code : lit_code, sel_len);
`else
        sel_code = rd_sel ? dist_code : lit_code;
`endif
    end

    // Build sequencer with registered status and read outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            fin_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rd_code <= '0;
            rd_len  <= '0;
        end else begin
            fin_q   <= fin;
            rd_code <= done ? sel_code : '0;
            rd_len  <= done ? sel_len : '0;
            if (lit_err || dist_err) err <= 1'b1;
            unique case (state)
                StLCount:  if (lit_ready)  state <= StLNext;
                StLNext:   if (lit_ready)  state <= StLAssign;
                StLAssign: if (lit_ready)  state <= StDCount;
                StDCount:  if (dist_ready) state <= StDNext;
                StDNext:   if (dist_ready) state <= StDAssign;
                StDAssign: begin
                    if (dist_ready) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (start) begin
                state <= StLCount;
                busy  <= 1'b1;
                done  <= 1'b0;
                err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_canon_code_gen.sv
// Directed bench for canon_code_gen: build timing, code values, error flag,
// reset abort, restart rules and out-of-range reads.
module tb_canon_code_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         fin;
    logic [115:0] lit_tree;
    logic [63:0]  dist_tree;
    logic         rd_sel;
    logic [4:0]   rd_sym;
    logic [7:0]   rd_code;
    logic [3:0]   rd_len;
    logic         busy;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb[$];

    canon_code_gen dut (
        .clk      (clk),
        .rst      (rst),
        .fin      (fin),
        .litTree  (lit_tree),
        .distTree (dist_tree),
        .rd_sel   (rd_sel),
        .rd_sym   (rd_sym),
        .rd_code  (rd_code),
        .rd_len   (rd_len),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected code as seen on rd_code for a given MSB-first code and length
    function automatic logic [7:0] exp_code(input logic [7:0] c, input int len);
        logic [7:0] r;
        r = c;
`ifdef CANON_BITREV_EN
        r = '0;
        for (int i = 0; i < len; i++) r[len - 1 - i] = c[i];
`endif
        return r;
    endfunction

    task automatic rd(input logic sel, input int sym, input logic [7:0] ec, input int el);
        logic [11:0] e;
        rd_sel = sel;
        rd_sym = 5'(sym);
        sb.push_back({exp_code(ec, el), 4'(el)});
        tick();
        e = sb.pop_front();
        check($sformatf("rd_code sel%0d sym%0d", sel, sym), int'(rd_code), int'(e[11:4]));
        check($sformatf("rd_len sel%0d sym%0d", sel, sym), int'(rd_len), int'(e[3:0]));
    endtask

    // Raise fin, then count cycles from the start edge until done rises
    task automatic run_build(input string tag, input int toggle_at);
        int n;
        fin = 1'b1;
        tick();
        check({tag, " busy at start"}, int'(busy), 1);
        check({tag, " done cleared"}, int'(done), 0);
        check({tag, " err cleared"}, int'(err), 0);
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
            if (n == toggle_at) fin = 1'b0;
            if (n == toggle_at + 1) fin = 1'b1;
        end
        check({tag, " build cycles"}, n, 106);
        check({tag, " busy after"}, int'(busy), 0);
    endtask

    task automatic set_lit(input int l0, input int l1, input int l2, input int l3,
                           input int rest);
        for (int k = 0; k < 29; k++) lit_tree[4*k +: 4] = 4'(rest);
        lit_tree[3:0]   = 4'(l0);
        lit_tree[7:4]   = 4'(l1);
        lit_tree[11:8]  = 4'(l2);
        lit_tree[15:12] = 4'(l3);
    endtask

    initial begin
        rst       = 1'b1;
        fin       = 1'b0;
        rd_sel    = 1'b0;
        rd_sym    = '0;
        lit_tree  = '0;
        dist_tree = '0;
        tick();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        check("reset rd_code", int'(rd_code), 0);
        check("reset rd_len", int'(rd_len), 0);
        rst = 1'b0;
        tick();
        rd(1'b0, 0, 8'd0, 0);

        // Uniform lengths: code equals symbol index
        set_lit(5, 5, 5, 5, 5);
        for (int k = 0; k < 16; k++) dist_tree[4*k +: 4] = 4'd4;
        run_build("uniform", 0);
        check("uniform err", int'(err), 0);
        rd(1'b0, 0, 8'd0, 5);
        rd(1'b0, 1, 8'd1, 5);
        rd(1'b0, 13, 8'd13, 5);
        rd(1'b0, 28, 8'd28, 5);
        rd(1'b1, 0, 8'd0, 4);
        rd(1'b1, 7, 8'd7, 4);
        rd(1'b1, 15, 8'd15, 4);
        rd(1'b1, 16, 8'd0, 0);

        // fin held high in DONE must not restart
        repeat (5) tick();
        check("hold busy", int'(busy), 0);
        check("hold done", int'(done), 1);
        rd(1'b0, 29, 8'd0, 0);
        rd(1'b0, 3, 8'd3, 5);

        // Lengths 1,2,3,3
        fin = 1'b0;
        tick();
        set_lit(1, 2, 3, 3, 0);
        run_build("mixed", 0);
        check("mixed err", int'(err), 0);
        rd(1'b0, 0, 8'b0, 1);
        rd(1'b0, 1, 8'b10, 2);
        rd(1'b0, 2, 8'b110, 3);
        rd(1'b0, 3, 8'b111, 3);
        rd(1'b0, 4, 8'd0, 0);

        // Oversubscribed distance set still completes on time
        fin = 1'b0;
        tick();
        dist_tree = '0;
        dist_tree[11:0] = 12'h111;
        run_build("oversub", 0);
        check("oversub err", int'(err), 1);
        check("oversub done", int'(done), 1);
        rd(1'b1, 3, 8'd0, 0);
        rd(1'b0, 1, 8'b10, 2);

        // Length 9 is flagged and reads as an unused symbol; err clears on start
        fin = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) dist_tree[4*k +: 4] = 4'd4;
        set_lit(1, 2, 3, 3, 0);
        lit_tree[23:20] = 4'd9;
        run_build("len9", 0);
        check("len9 err", int'(err), 1);
        rd(1'b0, 5, 8'd0, 0);
        rd(1'b0, 3, 8'b111, 3);

        // Reset mid-build with fin held high
        fin = 1'b0;
        tick();
        set_lit(1, 2, 3, 3, 0);
        fin = 1'b1;
        tick();
        repeat (50) tick();
        check("midrst busy before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst err", int'(err), 0);
        check("midrst rd_code", int'(rd_code), 0);
        check("midrst rd_len", int'(rd_len), 0);
        rd(1'b0, 1, 8'd0, 0);
        tick();
        rst = 1'b0;
        // fin pulses low then high mid-build; the re-rise is ignored while busy
        run_build("rerun", 30);
        check("rerun err", int'(err), 0);
        rd(1'b0, 1, 8'b10, 2);
        rd(1'b1, 15, 8'd15, 4);
        repeat (3) tick();
        check("rerun hold busy", int'(busy), 0);
        check("rerun hold done", int'(done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
